uart_cmd_sequencer: RTL and testbench

Parametrised UART command sequencer for the masked 2D filter processor. It decodes command bytes from the UART receiver and routes payload bytes to the parameter, mask and image stores. It runs the kernel and then the output send, and returns an ACK or NACK byte to the UART transmitter. Compared with the fixed-parameter controller it adds multi-byte parameters with an index byte, an inter-byte timeout, error reporting and a TX handshake.

---
 rtl/uart_cmd_sequencer.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer.sv
// Decodes UART command bytes, steers payload into the parameter/mask/image stores, runs kernel+send and returns one ACK/NACK byte.
// All outputs registered (one cycle after the causing rx_dv/handshake); the response waits in ACK while tx_busy is high.
module uart_cmd_sequencer #(
    parameter int NUM_PARAMS  = 4,
    parameter int PARAM_BYTES = 2,
    parameter int MASK_BYTES  = 11,
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 100000,
    localparam int IDX_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1,
    localparam int MA_W  = (MASK_BYTES > 1) ? $clog2(MASK_BYTES) : 1,
    localparam int PD_W  = 8 * PARAM_BYTES,
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_dv,
    input  logic [7:0]       rx_byte,
    input  logic [LEN_W-1:0] input_len,
    input  logic             kernel_done,
    input  logic             send_done,
    input  logic             tx_busy,
    output logic             param_wr,
    output logic [IDX_W-1:0] param_idx,
    output logic [PD_W-1:0]  param_data,
    output logic             mask_wr,
    output logic [MA_W-1:0]  mask_addr,
    output logic             img_wr,
    output logic [LEN_W-1:0] img_addr,
    output logic [7:0]       wr_byte,
    output logic             run_kernel,
    output logic             in_addr_sel,
    output logic             start_send,
    output logic             tx_dv,
    output logic [7:0]       tx_byte,
    output logic             busy,
    output logic [3:0]       o_state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_P_IDX  = 4'd1,
        S_P_DATA = 4'd2,
        S_MASK   = 4'd3,
        S_IMG    = 4'd4,
        S_RUN    = 4'd5,
        S_SEND   = 4'd6,
        S_ACK    = 4'd7
    } state_t;

    localparam logic [7:0] CMD_P  = 8'h70;
    localparam logic [7:0] CMD_M  = 8'h6D;
    localparam logic [7:0] CMD_I  = 8'h69;
    localparam logic [7:0] CMD_S  = 8'h73;
    localparam logic [7:0] CMD_O  = 8'h6F;
    localparam logic [7:0] RESP_A = 8'h41;
    localparam logic [7:0] RESP_E = 8'h45;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              bad_q, bad_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PD_W-1:0]   asm_q, asm_d;
    logic [7:0]        resp_q, resp_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    logic              param_wr_q, param_wr_d;
    logic [IDX_W-1:0]  param_idx_q, param_idx_d;
    logic [PD_W-1:0]   param_data_q, param_data_d;
    logic              mask_wr_q, mask_wr_d;
    logic [MA_W-1:0]   mask_addr_q, mask_addr_d;
    logic              img_wr_q, img_wr_d;
    logic [LEN_W-1:0]  img_addr_q, img_addr_d;
    logic [7:0]        wr_byte_q, wr_byte_d;
    logic              run_q, run_d;
    logic              sel_q, sel_d;
    logic              start_send_q, start_send_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              busy_q, busy_d;
    logic              timed;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        bad_d        = bad_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        resp_d       = resp_q;
        tmo_d        = '0;
        param_wr_d   = 1'b0;
        param_idx_d  = param_idx_q;
        param_data_d = param_data_q;
        mask_wr_d    = 1'b0;
        mask_addr_d  = mask_addr_q;
        img_wr_d     = 1'b0;
        img_addr_d   = img_addr_q;
        wr_byte_d    = wr_byte_q;
        run_d        = run_q;
        sel_d        = sel_q;
        start_send_d = 1'b0;
        tx_dv_d      = 1'b0;
        tx_byte_d    = tx_byte_q;

        timed = (state_q == S_P_IDX) || (state_q == S_P_DATA) ||
                (state_q == S_MASK)  || (state_q == S_IMG);
        if (timed && !rx_dv) begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_dv) begin
                    cnt_d = '0;
                    bad_d = 1'b0;
                    asm_d = '0;
                    case (rx_byte)
                        CMD_P: state_d = S_P_IDX;
                        CMD_M: state_d = S_MASK;
                        CMD_I: begin
                            len_d = input_len;
                            if (input_len == '0) begin
                                resp_d  = RESP_A;
                                state_d = S_ACK;
                            end else begin
                                state_d = S_IMG;
                            end
                        end
                        CMD_S: begin
                            run_d   = 1'b1;
                            sel_d   = 1'b1;
                            state_d = S_RUN;
                        end
                        CMD_O: begin
                            start_send_d = 1'b1;
                            state_d      = S_SEND;
                        end
                        default: begin
                            resp_d  = RESP_E;
                            state_d = S_ACK;
                        end
                    endcase
                end
            end
            S_P_IDX: begin
                if (rx_dv) begin
                    idx_d   = rx_byte[IDX_W-1:0];
                    bad_d   = ({24'd0, rx_byte} >= 32'(NUM_PARAMS));
                    state_d = S_P_DATA;
                end
            end
            S_P_DATA: begin
                if (rx_dv) begin
                    // cnt_q is the byte position; byte k lands in bits [8k+7:8k]
                    for (int k = 0; k < PARAM_BYTES; k++) begin
                        if (cnt_q == LEN_W'(k)) begin
                            asm_d[8*k +: 8] = rx_byte;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LEN_W'(PARAM_BYTES - 1)) begin
                        if (!bad_q) begin
                            param_wr_d   = 1'b1;
                            param_idx_d  = idx_q;
                            param_data_d = asm_d;
                            resp_d       = RESP_A;
                        end else begin
                            resp_d = RESP_E;
                        end
                        state_d = S_ACK;
                    end
                end
            end
            S_MASK: begin
                if (rx_dv) begin
                    mask_wr_d   = 1'b1;
                    mask_addr_d = cnt_q[MA_W-1:0];
                    wr_byte_d   = rx_byte;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == LEN_W'(MASK_BYTES - 1)) begin
                        resp_d  = RESP_A;
                        state_d = S_ACK;
                    end
                end
            end
            S_IMG: begin
                if (rx_dv) begin
                    img_wr_d   = 1'b1;
                    img_addr_d = cnt_q;
                    wr_byte_d  = rx_byte;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        resp_d  = RESP_A;
                        state_d = S_ACK;
                    end
                end
            end
            S_RUN: begin
                if (kernel_done) begin
                    run_d        = 1'b0;
                    sel_d        = 1'b0;
                    start_send_d = 1'b1;
                    state_d      = S_SEND;
                end
            end
            S_SEND: begin
                if (send_done) begin
                    resp_d  = RESP_A;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!tx_busy) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = resp_q;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A byte arriving on the expiry cycle takes priority over the abort
        if (timed && !rx_dv && (tmo_q == TMO_W'(TIMEOUT_CYC - 1))) begin
            resp_d  = RESP_E;
            state_d = S_ACK;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            bad_q        <= 1'b0;
            idx_q        <= '0;
            asm_q        <= '0;
            resp_q       <= '0;
            tmo_q        <= '0;
            param_wr_q   <= 1'b0;
            param_idx_q  <= '0;
            param_data_q <= '0;
            mask_wr_q    <= 1'b0;
            mask_addr_q  <= '0;
            img_wr_q     <= 1'b0;
            img_addr_q   <= '0;
            wr_byte_q    <= '0;
            run_q        <= 1'b0;
            sel_q        <= 1'b0;
            start_send_q <= 1'b0;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            bad_q        <= bad_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            resp_q       <= resp_d;
            tmo_q        <= tmo_d;
            param_wr_q   <= param_wr_d;
            param_idx_q  <= param_idx_d;
            param_data_q <= param_data_d;
            mask_wr_q    <= mask_wr_d;
            mask_addr_q  <= mask_addr_d;
            img_wr_q     <= img_wr_d;
            img_addr_q   <= img_addr_d;
            wr_byte_q    <= wr_byte_d;
            run_q        <= run_d;
            sel_q        <= sel_d;
            start_send_q <= start_send_d;
            tx_dv_q      <= tx_dv_d;
            tx_byte_q    <= tx_byte_d;
            busy_q       <= busy_d;
        end
    end

    assign param_wr    = param_wr_q;
    assign param_idx   = param_idx_q;
    assign param_data  = param_data_q;
    assign mask_wr     = mask_wr_q;
    assign mask_addr   = mask_addr_q;
    assign img_wr      = img_wr_q;
    assign img_addr    = img_addr_q;
    assign wr_byte     = wr_byte_q;
    assign run_kernel  = run_q;
    assign in_addr_sel = sel_q;
    assign start_send  = start_send_q;
    assign tx_dv       = tx_dv_q;
    assign tx_byte     = tx_byte_q;
    assign busy        = busy_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: parameter table, directed corner sequences, then random commands against a transaction-level model.
module tb_uart_cmd_sequencer;

    localparam int NP  = 4;
    localparam int PB  = 2;
    localparam int MB  = 11;
    localparam int LW  = 16;
    localparam int TMO = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_dv = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic [LW-1:0] input_len = '0;
    logic          kernel_done = 1'b0;
    logic          send_done = 1'b0;
    logic          tx_busy = 1'b0;
    logic          param_wr;
    logic [1:0]    param_idx;
    logic [15:0]   param_data;
    logic          mask_wr;
    logic [3:0]    mask_addr;
    logic          img_wr;
    logic [LW-1:0] img_addr;
    logic [7:0]    wr_byte;
    logic          run_kernel, in_addr_sel, start_send, tx_dv, busy;
    logic [7:0]    tx_byte;
    logic [3:0]    o_state;

    uart_cmd_sequencer #(
        .NUM_PARAMS(NP), .PARAM_BYTES(PB), .MASK_BYTES(MB), .LEN_W(LW), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte), .input_len(input_len),
        .kernel_done(kernel_done), .send_done(send_done), .tx_busy(tx_busy),
        .param_wr(param_wr), .param_idx(param_idx), .param_data(param_data),
        .mask_wr(mask_wr), .mask_addr(mask_addr), .img_wr(img_wr), .img_addr(img_addr),
        .wr_byte(wr_byte), .run_kernel(run_kernel), .in_addr_sel(in_addr_sel),
        .start_send(start_send), .tx_dv(tx_dv), .tx_byte(tx_byte), .busy(busy), .o_state(o_state)
    );

    always #5 clk = ~clk;

    typedef struct { int a; int d; } ev_t;
    typedef struct {
        logic [7:0]  idx, b0, b1;
        logic        exp_wr;
        logic [15:0] exp_data;
        logic [7:0]  exp_resp;
    } pv_t;

    int         n_cmp = 0;
    int         n_err = 0;
    int         ss_n  = 0;
    ev_t        pw_q[$], mw_q[$], iw_q[$], e_pw[$], e_mw[$], e_iw[$];
    logic [7:0] tx_q[$];
    logic [7:0] pay[$];

    always @(negedge clk) begin
        if (param_wr) pw_q.push_back('{int'(param_idx), int'(param_data)});
        if (mask_wr)  mw_q.push_back('{int'(mask_addr), int'(wr_byte)});
        if (img_wr)   iw_q.push_back('{int'(img_addr), int'(wr_byte)});
        if (tx_dv)    tx_q.push_back(tx_byte);
        if (start_send) ss_n++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic rx(input logic [7:0] b);
        @(posedge clk); #1;
        rx_dv = 1'b1; rx_byte = b;
        @(posedge clk); #1;
        rx_dv = 1'b0;
    endtask

    task automatic send_pay(input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            rx(pay[i]);
            repeat ($urandom_range(0, maxgap)) @(posedge clk);
        end
    endtask

    task automatic cmpq(input string nm, input ev_t act[$], input ev_t exp[$]);
        chk({nm, " count"}, act.size(), exp.size());
        for (int i = 0; i < act.size() && i < exp.size(); i++) begin
            chk({nm, " addr"}, act[i].a, exp[i].a);
            chk({nm, " data"}, act[i].d, exp[i].d);
        end
    endtask

    task automatic finish_cmd(input string nm, input logic [7:0] exp_resp);
        int w = 0;
        while (tx_q.size() == 0 && w < TMO * 4) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk({nm, " resp count"}, tx_q.size(), 1);
        if (tx_q.size() > 0) chk({nm, " resp byte"}, tx_q[0], exp_resp);
        chk({nm, " back to idle"}, o_state, 0);
        cmpq({nm, " param"}, pw_q, e_pw);
        cmpq({nm, " mask"}, mw_q, e_mw);
        cmpq({nm, " img"}, iw_q, e_iw);
        tx_q.delete(); pw_q.delete(); mw_q.delete(); iw_q.delete();
        e_pw.delete(); e_mw.delete(); e_iw.delete();
    endtask

    task automatic check_quiet(input string nm);
        chk({nm, " strobes"}, {param_wr, mask_wr, img_wr, run_kernel, in_addr_sel, start_send, tx_dv, busy}, 0);
        chk({nm, " state"}, o_state, 0);
        chk({nm, " data regs"}, {param_data, tx_byte, wr_byte}, 0);
        chk({nm, " addr regs"}, {param_idx, mask_addr, img_addr}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pv_t ptab[5];
        int  s0, hi, sel, n, len, kind, idx, v;
        logic [7:0] b;

        ptab[0] = '{8'h02, 8'h34, 8'h12, 1'b1, 16'h1234, 8'h41};
        ptab[1] = '{8'h07, 8'hAA, 8'hBB, 1'b0, 16'h0000, 8'h45};
        ptab[2] = '{8'h00, 8'hFF, 8'h00, 1'b1, 16'h00FF, 8'h41};
        ptab[3] = '{8'h03, 8'h01, 8'h80, 1'b1, 16'h8001, 8'h41};
        ptab[4] = '{8'h04, 8'h11, 8'h22, 1'b0, 16'h0000, 8'h45};

        repeat (3) @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1 rst = 1'b1;

        for (int t = 0; t < 5; t++) begin
            rx(8'h70); rx(ptab[t].idx); rx(ptab[t].b0); rx(ptab[t].b1);
            if (ptab[t].exp_wr) e_pw.push_back('{int'(ptab[t].idx), int'(ptab[t].exp_data)});
            finish_cmd("param table", ptab[t].exp_resp);
        end

        for (int pass = 0; pass < 2; pass++) begin
            tx_busy = (pass == 1);
            rx(8'h6D);
            for (int k = 0; k < MB; k++) begin
                rx(8'(k + 1));
                e_mw.push_back('{k, k + 1});
            end
            if (pass == 1) begin
                repeat (20) @(negedge clk);
                chk("mask tx held while busy", tx_q.size(), 0);
                chk("mask waits in ACK", o_state, 7);
                @(posedge clk); #1 tx_busy = 1'b0;
            end
            finish_cmd("mask", 8'h41);
        end

        input_len = 16'd5;
        rx(8'h69);
        for (int k = 0; k < 3; k++) begin
            rx(8'hA0 + 8'(k));
            e_iw.push_back('{k, 'hA0 + k});
        end
        repeat (TMO - 1) @(posedge clk);
        @(negedge clk);
        chk("img still loading before expiry", o_state, 4);
        @(posedge clk);
        @(negedge clk);
        chk("img aborted at expiry", o_state, 7);
        finish_cmd("img timeout", 8'h45);

        input_len = 16'd0;
        rx(8'h69);
        finish_cmd("img zero length", 8'h41);

        rx(8'h70); rx(8'h01); rx(8'h55);
        repeat (TMO - 2) @(posedge clk);
        rx(8'h66);
        e_pw.push_back('{1, 'h6655});
        finish_cmd("byte beats timeout", 8'h41);

        s0 = ss_n; hi = 0; sel = 0;
        rx(8'h73);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (run_kernel) hi++;
            if (in_addr_sel) sel++;
            rx_dv = (i == 10);
            rx_byte = 8'h78;
        end
        kernel_done = 1'b1;
        @(negedge clk);
        kernel_done = 1'b0;
        chk("run_kernel cycles", hi, 50);
        chk("in_addr_sel cycles", sel, 50);
        chk("run_kernel dropped", {run_kernel, in_addr_sel}, 0);
        chk("in SEND after kernel", o_state, 6);
        repeat (5) @(posedge clk);
        #1 send_done = 1'b1;
        @(posedge clk); #1 send_done = 1'b0;
        chk("start_send pulses", ss_n - s0, 1);
        finish_cmd("run", 8'h41);

        rx(8'h6D);
        for (int k = 0; k < 4; k++) begin
            rx(8'h30 + 8'(k));
            e_mw.push_back('{k, 'h30 + k});
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_quiet("mid-mask reset");
        @(posedge clk); #1 rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("no response after reset", tx_q.size(), 0);
        cmpq("mask before reset", mw_q, e_mw);
        mw_q.delete(); e_mw.delete();
        rx(8'h71);
        finish_cmd("unknown after reset", 8'h45);

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 4);
            pay.delete();
            case (kind)
                0: begin
                    idx = $urandom_range(0, 6);
                    pay.push_back(8'(idx));
                    for (int k = 0; k < PB; k++) pay.push_back(8'($urandom_range(0, 255)));
                    n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, PB) : PB + 1;
                    rx(8'h70);
                    send_pay(n, 3);
                    v = 0;
                    for (int k = 0; k < PB; k++) v += int'(pay[k + 1]) * (1 << (8 * k));
                    if (n == PB + 1 && idx < NP) e_pw.push_back('{idx, v});
                    tx_busy = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    tx_busy = 1'b0;
                    finish_cmd("rand param", (n == PB + 1 && idx < NP) ? 8'h41 : 8'h45);
                end
                1: begin
                    for (int k = 0; k < MB; k++) pay.push_back(8'($urandom_range(0, 255)));
                    n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MB - 1) : MB;
                    rx(8'h6D);
                    send_pay(n, 3);
                    for (int k = 0; k < n; k++) e_mw.push_back('{k, int'(pay[k])});
                    finish_cmd("rand mask", (n == MB) ? 8'h41 : 8'h45);
                end
                2: begin
                    len = $urandom_range(0, 8);
                    for (int k = 0; k < len; k++) pay.push_back(8'($urandom_range(0, 255)));
                    n = ($urandom_range(0, 3) == 0 && len > 0) ? $urandom_range(0, len - 1) : len;
                    input_len = LW'(len);
                    rx(8'h69);
                    send_pay(n, 3);
                    for (int k = 0; k < n; k++) e_iw.push_back('{k, int'(pay[k])});
                    finish_cmd("rand img", (n == len) ? 8'h41 : 8'h45);
                end
                3: begin
                    s0 = ss_n;
                    if ($urandom_range(0, 1) == 1) begin
                        rx(8'h73);
                        repeat ($urandom_range(1, 8)) @(posedge clk);
                        #1 kernel_done = 1'b1;
                        @(posedge clk); #1 kernel_done = 1'b0;
                    end else begin
                        rx(8'h6F);
                    end
                    repeat ($urandom_range(1, 5)) @(posedge clk);
                    #1 send_done = 1'b1;
                    @(posedge clk); #1 send_done = 1'b0;
                    chk("rand start_send pulses", ss_n - s0, 1);
                    finish_cmd("rand run/send", 8'h41);
                end
                default: begin
                    b = 8'($urandom_range(0, 255));
                    while (b == 8'h70 || b == 8'h6D || b == 8'h69 || b == 8'h73 || b == 8'h6F)
                        b = 8'($urandom_range(0, 255));
                    rx(b);
                    finish_cmd("rand unknown cmd", 8'h45);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
